sigmoid_lut_sched: RTL and testbench

- Shares one sigmoid lookup path among N_REQ LSTM gate requesters (input, forget, output gates). The path is the existing sigmoid_addr_calc plus an external synchronous sigmoid ROM.
- Round-robin arbitration, one accept per cycle, 2-deep pipeline with full backpressure.
- Applies sign symmetry, sigmoid(-x) = ONE - sigmoid(x), and saturation for out-of-range inputs.
- Returns each result tagged with the requester id.

---
 rtl/sigmoid_lut_sched.sv | 175 +++++++++++++++++
 tb/tb_sigmoid_lut_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_lut_sched.sv
// Shared sigmoid lookup path for several LSTM gate requesters.
// Round-robin arbitration feeds one address calculator and an external
// synchronous ROM; sign symmetry and saturation are applied on the way out,
// and each result carries the id of the requester that issued it.

// Maps a sign-magnitude operand magnitude onto a ROM address and flags
// magnitudes beyond the table range.
module sigmoid_addr_calc #(
    parameter int IN_W   = 12,
    parameter int ADDR_W = 9
) (
    input  logic [IN_W-2:0]   mag_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              oor_o
);
    assign addr_o = mag_i[ADDR_W-1:0];
    assign oor_o  = (mag_i > (IN_W-1)'(12'h180));
endmodule

module sigmoid_lut_sched #(
    parameter int              N_REQ  = 3,
    parameter int              IN_W   = 12,
    parameter int              ADDR_W = 9,
    parameter int              OUT_W  = 12,
    parameter logic [OUT_W-1:0] ONE   = 12'h400,
    parameter int              ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*IN_W-1:0] req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  lut_en,
    output logic [ADDR_W-1:0]     lut_addr,
    input  logic [OUT_W-1:0]      lut_rdata,
    output logic                  res_valid,
    output logic [OUT_W-1:0]      res_data,
    output logic [ID_W-1:0]       res_id,
    input  logic                  res_ready,
    output logic                  busy
);

    // Symmetry and saturation: sigmoid(-x) = ONE - sigmoid(x); out-of-range
    // inputs clamp to the asymptote matching their sign.
    function automatic logic [OUT_W-1:0] sym_sat(input logic sign,
                                                 input logic oor,
                                                 input logic [OUT_W-1:0] rd);
        logic [OUT_W-1:0] r;
        if (oor) r = sign ? '0 : ONE;
        else     r = sign ? (ONE - rd) : rd;
        return r;
    endfunction

    logic              stall;
    logic              accept;
    logic              found;
    logic [ID_W-1:0]   grant_idx;
    logic [N_REQ-1:0]  grant_vec;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IN_W-1:0]   sel_data;
    logic [ADDR_W-1:0] calc_addr;
    logic              calc_oor;

    // Stage 1: address register, sign/range/id of the accepted request
    logic              s1_v_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic              s1_sign_q, s1_oor_q;
    logic [ID_W-1:0]   s1_id_q;

    // Stage 2: ROM read in flight; lut_rdata belongs to this entry
    logic              s2_v_q;
    logic              s2_sign_q, s2_oor_q;
    logic [ID_W-1:0]   s2_id_q;

    // Output stage
    logic              res_v_q;
    logic [OUT_W-1:0]  res_data_q, res_data_d;
    logic [ID_W-1:0]   res_id_q;

    assign stall = res_v_q & ~res_ready;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        logic [ID_W-1:0] cand;
        found     = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (found) grant_vec[grant_idx] = 1'b1;
    end

    assign accept    = found & ~stall;
    assign req_ready = grant_vec & {N_REQ{~stall}};
    assign sel_data  = req_data[int'(grant_idx)*IN_W +: IN_W];
    assign rr_ptr_d  = accept ? grant_idx : rr_ptr_q;

    sigmoid_addr_calc #(
        .IN_W   (IN_W),
        .ADDR_W (ADDR_W)
    ) u_addr_calc (
        .mag_i  (sel_data[IN_W-2:0]),
        .addr_o (calc_addr),
        .oor_o  (calc_oor)
    );

    // Round-robin pointer; reset value gives requester 0 top priority.
    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= ID_W'(N_REQ - 1);
        else     rr_ptr_q <= rr_ptr_d;
    end

    // Stage 1 load on accept; bubbles in when idle; holds during stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_addr_q <= '0;
            s1_sign_q <= 1'b0;
            s1_oor_q  <= 1'b0;
            s1_id_q   <= '0;
        end else if (!stall) begin
            s1_v_q <= accept;
            if (accept) begin
                s1_addr_q <= calc_addr;
                s1_sign_q <= sel_data[IN_W-1];
                s1_oor_q  <= calc_oor;
                s1_id_q   <= grant_idx;
            end
        end
    end

    // Stage 2 tracks the entry whose ROM read is being performed.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v_q    <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_oor_q  <= 1'b0;
            s2_id_q   <= '0;
        end else if (!stall) begin
            s2_v_q    <= s1_v_q;
            s2_sign_q <= s1_sign_q;
            s2_oor_q  <= s1_oor_q;
            s2_id_q   <= s1_id_q;
        end
    end

    assign res_data_d = sym_sat(s2_sign_q, s2_oor_q, lut_rdata);

    // Output register; held result stays stable until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_v_q    <= 1'b0;
            res_data_q <= '0;
            res_id_q   <= '0;
        end else if (!stall) begin
            res_v_q    <= s2_v_q;
            res_data_q <= res_data_d;
            res_id_q   <= s2_id_q;
        end
    end

    assign lut_en    = s1_v_q & ~stall;
    assign lut_addr  = s1_addr_q;
    assign res_valid = res_v_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = s1_v_q | s2_v_q | res_v_q;

endmodule

// File: tb/tb_sigmoid_lut_sched.sv
// Bench for sigmoid_lut_sched: ROM model lut[a] = 0x200 + a, scoreboard of
// expected results pushed at accept and popped when results are consumed.
module tb_sigmoid_lut_sched;

    localparam int N_REQ = 3;
    localparam int IN_W  = 12;
    localparam int OUT_W = 12;
    localparam int ID_W  = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N_REQ-1:0]      req_valid = '0;
    logic [N_REQ*IN_W-1:0] req_data = '0;
    logic [N_REQ-1:0]      req_ready;
    logic                  lut_en;
    logic [8:0]            lut_addr;
    logic [OUT_W-1:0]      lut_rdata = '0;
    logic                  res_valid;
    logic [OUT_W-1:0]      res_data;
    logic [ID_W-1:0]       res_id;
    logic                  res_ready = 1'b1;
    logic                  busy;

    int vectors = 0;
    int miscompares = 0;
    logic [ID_W+OUT_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    sigmoid_lut_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .lut_en    (lut_en),
        .lut_addr  (lut_addr),
        .lut_rdata (lut_rdata),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready),
        .busy      (busy)
    );

    // Synchronous ROM: output holds when lut_en is low.
    always @(posedge clk) begin
        if (lut_en) lut_rdata <= 12'h200 + {3'b000, lut_addr};
    end

    function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] d);
        logic [10:0] mag;
        logic [OUT_W-1:0] lut;
        mag = d[10:0];
        lut = 12'h200 + {3'b000, mag[8:0]};
        if (mag > 11'h180) return d[11] ? 12'h000 : 12'h400;
        return d[11] ? (12'h400 - lut) : lut;
    endfunction

    // Scoreboard: compare consumed results, then record new accepts.
    always @(negedge clk) begin
        logic [ID_W+OUT_W-1:0] e;
        if (!rst) begin
            if (res_valid && res_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected: got id=%0d data=%h, required no result", res_id, res_data);
                end else begin
                    e = exp_q.pop_front();
                    if (res_data !== e[OUT_W-1:0] || res_id !== e[ID_W+OUT_W-1:OUT_W]) begin
                        miscompares++;
                        $display("FAIL sb_result: got id=%0d data=%h, required id=%0d data=%h",
                                 res_id, res_data, e[ID_W+OUT_W-1:OUT_W], e[OUT_W-1:0]);
                    end
                end
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && req_ready[i])
                    exp_q.push_back({ID_W'(i), model(req_data[i*IN_W +: IN_W])});
            end
        end
    end

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        vectors++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d pending busy=%b, required 0 pending busy=0", name, exp_q.size(), busy);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({res_valid, busy, lut_en, req_ready} !== 6'b0 || lut_addr !== 9'h0 ||
            res_data !== 12'h0 || res_id !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state: got rv=%b busy=%b en=%b rdy=%b addr=%h data=%h id=%0d, required all 0",
                     res_valid, busy, lut_en, req_ready, lut_addr, res_data, res_id);
        end
        rst = 1'b0;
    endtask

    // Single request from requester 0 with explicit latency and value checks.
    task automatic test_one(input logic [IN_W-1:0] d, input logic [OUT_W-1:0] expv);
        @(posedge clk); #1;
        req_valid = 3'b001;
        req_data[0 +: IN_W] = d;
        @(negedge clk);
        vectors++;
        if (req_ready !== 3'b001) begin
            miscompares++;
            $display("FAIL one_grant(%h): got %b, required 001", d, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 3'b000;
        @(posedge clk); #1;
        vectors++;
        if (res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL one_early(%h): got res_valid=%b, required 0", d, res_valid);
        end
        @(posedge clk); #1;
        vectors++;
        if (res_valid !== 1'b1 || res_data !== expv || res_id !== 2'd0) begin
            miscompares++;
            $display("FAIL one_result(%h): got v=%b data=%h id=%0d, required v=1 data=%h id=0",
                     d, res_valid, res_data, res_id, expv);
        end
        wait_drain("one");
    endtask

    task automatic test_values();
        logic [IN_W-1:0]  din [7]  = '{12'h020, 12'h820, 12'h200, 12'hA00, 12'h180, 12'h181, 12'h800};
        logic [OUT_W-1:0] dexp[7]  = '{12'h220, 12'h1E0, 12'h400, 12'h000, 12'h380, 12'h400, 12'h200};
        for (int i = 0; i < 7; i++) test_one(din[i], dexp[i]);
    endtask

    task automatic test_round_robin();
        pulse_reset();
        @(posedge clk); #1;
        req_data  = {12'h1C0, 12'h851, 12'h010};
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            vectors++;
            if (req_ready !== 3'(1 << (k % 3))) begin
                miscompares++;
                $display("FAIL rr_grant[%0d]: got %b, required %b", k, req_ready, 3'(1 << (k % 3)));
            end
            if (k >= 3) begin
                vectors++;
                if (res_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rr_stream[%0d]: got res_valid=%b, required 1", k, res_valid);
                end
            end
            @(posedge clk); #1;
        end
        req_valid = 3'b000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (res_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL rr_tail[%0d]: got res_valid=%b, required 1", k, res_valid);
            end
            @(posedge clk); #1;
        end
        wait_drain("rr");
    endtask

    task automatic test_backpressure();
        logic [OUT_W-1:0] hd;
        logic [ID_W-1:0]  hi;
        @(posedge clk); #1;
        req_data  = {12'h0A5, 12'h8F0, 12'h13C};
        req_valid = 3'b111;
        repeat (3) begin
            @(posedge clk); #1;
        end
        res_ready = 1'b0;
        hd = res_data;
        hi = res_id;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (req_ready !== 3'b000 || lut_en !== 1'b0 || res_valid !== 1'b1 ||
                res_data !== hd || res_id !== hi) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got rdy=%b en=%b v=%b data=%h id=%0d, required rdy=000 en=0 v=1 data=%h id=%0d",
                         k, req_ready, lut_en, res_valid, res_data, res_id, hd, hi);
            end
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        req_valid = 3'b000;
        wait_drain("bp");
    endtask

    task automatic test_reset_inflight();
        @(posedge clk); #1;
        res_ready = 1'b0;
        req_data[0 +: IN_W] = 12'h030;
        req_valid = 3'b001;
        repeat (2) begin
            @(posedge clk); #1;
        end
        req_valid = 3'b000;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_flush: got res_valid=%b busy=%b, required 0 0", res_valid, busy);
        end
        rst = 1'b0;
        exp_q.delete();
        res_ready = 1'b1;
        req_data  = {12'h040, 12'h050, 12'h060};
        req_valid = 3'b111;
        @(negedge clk);
        vectors++;
        if (req_ready !== 3'b001) begin
            miscompares++;
            $display("FAIL rst_first_grant: got %b, required 001", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 3'b000;
        wait_drain("rst");
    endtask

    initial begin
        test_reset();
        test_values();
        test_round_robin();
        test_backpressure();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
